// File: rtl/axi4_ddr_slave_model.sv
// AXI4 slave with an internal RAM standing in for the DDR controller.
// Write and read channels run independently; reads see a fixed pipeline latency.
module axi4_ddr_slave_model #(
    parameter int unsigned pAxi4BusWidth = 512,
    parameter int unsigned pDepthBits    = 10,
    parameter int unsigned pReadLatency  = 4,
    parameter int unsigned pCfgDelay     = 32
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic [32:0]                  i_araddr,
    input  logic [7:0]                   i_arlen,
    input  logic [1:0]                   i_arburst,
    input  logic [5:0]                   i_arid,
    input  logic                         i_arvalid,
    output logic                         o_arready,
    output logic [pAxi4BusWidth-1:0]     o_rdata,
    output logic [5:0]                   o_rid,
    output logic [1:0]                   o_rresp,
    output logic                         o_rlast,
    output logic                         o_rvalid,
    input  logic                         i_rready,
    input  logic [32:0]                  i_awaddr,
    input  logic [7:0]                   i_awlen,
    input  logic [1:0]                   i_awburst,
    input  logic [5:0]                   i_awid,
    input  logic                         i_awvalid,
    output logic                         o_awready,
    input  logic [pAxi4BusWidth-1:0]     i_wdata,
    input  logic [pAxi4BusWidth/8-1:0]   i_wstrb,
    input  logic                         i_wlast,
    input  logic                         i_wvalid,
    output logic                         o_wready,
    output logic [5:0]                   o_bid,
    output logic [1:0]                   o_bresp,
    output logic                         o_bvalid,
    input  logic                         i_bready,
    output logic                         o_cfg_done,
    output logic                         o_wlast_err
);
    localparam int unsigned lpStrbW = pAxi4BusWidth / 8;
    localparam int unsigned lpLsb   = $clog2(lpStrbW);
    localparam int unsigned lpDepth = 1 << pDepthBits;

    typedef logic [pDepthBits-1:0] idx_t;
    typedef enum logic [1:0] {WIdle, WData, WResp} wstate_t;
    typedef enum logic [1:0] {RIdle, RWait, RData} rstate_t;

    logic [pAxi4BusWidth-1:0] mem [lpDepth];

    logic [15:0] cfg_cnt;
    logic        cfg_done;

    wstate_t     wstate;
    idx_t        widx;
    logic [7:0]  wlen, wcnt;
    logic        wfixed, werr, wready, bvalid, wlast_err;
    logic [5:0]  wid, bid;
    logic [1:0]  bresp;

    rstate_t     rstate;
    idx_t        ridx, ar_idx, r_next_idx;
    logic [7:0]  rlen, rcnt, lat;
    logic        rfixed, rvalid, rlast;
    logic [5:0]  rid;
    logic [pAxi4BusWidth-1:0] rdata;

    // Upper address bits alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_araddr[32:lpLsb+pDepthBits], i_araddr[lpLsb-1:0],
                                i_awaddr[32:lpLsb+pDepthBits], i_awaddr[lpLsb-1:0]};

    assign ar_idx     = i_araddr[lpLsb +: pDepthBits];
    assign r_next_idx = rfixed ? ridx : ridx + idx_t'(1);

    assign o_cfg_done  = cfg_done;
    assign o_awready   = (wstate == WIdle) && cfg_done;
    assign o_arready   = (rstate == RIdle) && cfg_done;
    assign o_wready    = wready;
    assign o_bvalid    = bvalid;
    assign o_bid       = bid;
    assign o_bresp     = bresp;
    assign o_wlast_err = wlast_err;
    assign o_rvalid    = rvalid;
    assign o_rlast     = rlast;
    assign o_rid       = rid;
    assign o_rdata     = rdata;
    assign o_rresp     = 2'b00;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            cfg_cnt  <= '0;
            cfg_done <= 1'b0;
        end else if (!cfg_done) begin
            cfg_cnt  <= cfg_cnt + 16'd1;
            cfg_done <= (cfg_cnt + 16'd1 == 16'(pCfgDelay));
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            wstate    <= WIdle;
            widx      <= '0;
            wlen      <= '0;
            wcnt      <= '0;
            wfixed    <= 1'b0;
            werr      <= 1'b0;
            wid       <= '0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= 2'b00;
            wlast_err <= 1'b0;
        end else begin
            case (wstate)
                WIdle: if (i_awvalid && o_awready) begin
                    widx   <= i_awaddr[lpLsb +: pDepthBits];
                    wlen   <= i_awlen;
                    wfixed <= (i_awburst == 2'b00);
                    wid    <= i_awid;
                    wcnt   <= '0;
                    werr   <= 1'b0;
                    wready <= 1'b1;
                    wstate <= WData;
                end
                WData: if (i_wvalid) begin
                    if (i_wlast != (wcnt == wlen)) begin
                        werr      <= 1'b1;
                        wlast_err <= 1'b1;
                    end
                    if (!wfixed) widx <= widx + idx_t'(1);
                    wcnt <= wcnt + 8'd1;
                    if (wcnt == wlen) begin
                        // This beat's own wlast check must feed the response too.
                        bresp  <= (werr || !i_wlast) ? 2'b10 : 2'b00;
                        bid    <= wid;
                        bvalid <= 1'b1;
                        wready <= 1'b0;
                        wstate <= WResp;
                    end
                end
                WResp: if (i_bready) begin
                    bvalid <= 1'b0;
                    wstate <= WIdle;
                end
                default: wstate <= WIdle;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (wstate == WData && i_wvalid) begin
            for (int b = 0; b < lpStrbW; b++) begin
                if (i_wstrb[b]) mem[widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rstate <= RIdle;
            ridx   <= '0;
            rlen   <= '0;
            rcnt   <= '0;
            lat    <= '0;
            rfixed <= 1'b0;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            rid    <= '0;
            rdata  <= '0;
        end else begin
            case (rstate)
                RIdle: if (i_arvalid && o_arready) begin
                    ridx   <= ar_idx;
                    rlen   <= i_arlen;
                    rfixed <= (i_arburst == 2'b00);
                    rid    <= i_arid;
                    rcnt   <= '0;
                    if (pReadLatency == 1) begin
                        rdata  <= mem[ar_idx];
                        rvalid <= 1'b1;
                        rlast  <= (i_arlen == 8'd0);
                        rstate <= RData;
                    end else begin
                        lat    <= 8'(pReadLatency - 1);
                        rstate <= RWait;
                    end
                end
                RWait: begin
                    if (lat == 8'd1) begin
                        rdata  <= mem[ridx];
                        rvalid <= 1'b1;
                        rlast  <= (rlen == 8'd0);
                        rstate <= RData;
                    end else begin
                        lat <= lat - 8'd1;
                    end
                end
                RData: if (i_rready) begin
                    if (rcnt == rlen) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        rstate <= RIdle;
                    end else begin
                        // Fetch the following word now so the next beat has no bubble.
                        ridx  <= r_next_idx;
                        rdata <= mem[r_next_idx];
                        rcnt  <= rcnt + 8'd1;
                        rlast <= (rcnt + 8'd1 == rlen);
                    end
                end
                default: rstate <= RIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_ddr_slave_model.sv
// Randomised scoreboard bench for axi4_ddr_slave_model against an array-based memory model.
module tb_axi4_ddr_slave_model;
    localparam int W   = 512;
    localparam int SB  = W / 8;
    localparam int DB  = 10;
    localparam int DEP = 1 << DB;
    localparam int LAT = 4;
    localparam int CFG = 32;

    logic          iCLK, iRST;
    logic [32:0]   i_araddr, i_awaddr;
    logic [7:0]    i_arlen, i_awlen;
    logic [1:0]    i_arburst, i_awburst;
    logic [5:0]    i_arid, i_awid;
    logic          i_arvalid, i_awvalid, i_rready, i_wlast, i_wvalid, i_bready;
    logic [W-1:0]  i_wdata;
    logic [SB-1:0] i_wstrb;
    logic          o_arready, o_rlast, o_rvalid, o_awready, o_wready, o_bvalid;
    logic          o_cfg_done, o_wlast_err;
    logic [W-1:0]  o_rdata;
    logic [5:0]    o_rid, o_bid;
    logic [1:0]    o_rresp, o_bresp;

    axi4_ddr_slave_model #(
        .pAxi4BusWidth(W), .pDepthBits(DB), .pReadLatency(LAT), .pCfgDelay(CFG)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arburst(i_arburst), .i_arid(i_arid),
        .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rid(o_rid), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready),
        .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awburst(i_awburst), .i_awid(i_awid),
        .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
        .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .o_cfg_done(o_cfg_done), .o_wlast_err(o_wlast_err)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int unsigned cyc = 0;
    always @(posedge iCLK) cyc++;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0]  model [DEP];
    logic [W-1:0]  exp_rdata [$];
    logic          exp_rlast [$];
    logic [5:0]    exp_rid   [$];
    logic [7:0]    exp_b     [$];
    logic [W-1:0]  wq_d [$];
    logic [SB-1:0] wq_s [$];

    int   rr_mode = 0;
    int   pat_k   = 0;
    logic [3:0] rr_pat = 4'b1001;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SB-1:0] rnd_strb();
        logic [SB-1:0] r;
        r = {$urandom, $urandom};
        return r;
    endfunction

    function automatic int idx_of(input logic [32:0] a);
        return int'(a[6 +: DB]);
    endfunction

    always @(posedge iCLK) begin
        #1;
        i_bready = ($urandom_range(0, 3) != 0);
        if (rr_mode != 0) begin
            i_rready = rr_pat[pat_k % 4];
            pat_k++;
        end else begin
            i_rready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expected beats/responses whenever the DUT completes a handshake.
    int unsigned hs_cyc;
    bit           lat_pending = 0;
    bit           stalled = 0;
    logic [W-1:0] prev_rdata;
    logic [6:0]   prev_meta;
    always @(negedge iCLK) begin
        if (!iRST) begin
            lat_pending = 0;
            stalled = 0;
        end else begin
            if (i_arvalid && o_arready) begin
                hs_cyc = cyc;
                lat_pending = 1;
            end
            if (o_rvalid) begin
                if (lat_pending) begin
                    check("rd_latency", W'(cyc - hs_cyc), W'(LAT));
                    lat_pending = 0;
                end
                if (stalled) begin
                    check("rdata_stable", o_rdata, prev_rdata);
                    check("rmeta_stable", W'({o_rlast, o_rid}), W'(prev_meta));
                end
                if (i_rready) begin
                    stalled = 0;
                    if (exp_rdata.size() == 0) begin
                        check("unexpected_rbeat", W'(1), W'(0));
                    end else begin
                        check("rdata", o_rdata, exp_rdata.pop_front());
                        check("rlast", W'(o_rlast), W'(exp_rlast.pop_front()));
                        check("rid", W'(o_rid), W'(exp_rid.pop_front()));
                        check("rresp", W'(o_rresp), W'(0));
                    end
                end else begin
                    stalled = 1;
                    prev_rdata = o_rdata;
                    prev_meta = {o_rlast, o_rid};
                end
            end
            if (o_bvalid && i_bready) begin
                if (exp_b.size() == 0) check("unexpected_bresp", W'(1), W'(0));
                else check("bid_bresp", W'({o_bid, o_bresp}), W'(exp_b.pop_front()));
            end
        end
    end

    task automatic wait_ready(input int which, output bit ok);
        int t = 0;
        ok = 1;
        forever begin
            @(negedge iCLK);
            if ((which == 0 && o_awready) || (which == 1 && o_wready) ||
                (which == 2 && o_arready)) break;
            if (++t > 200) begin
                ok = 0;
                n_vec++;
                n_err++;
                $display("FAIL ready_timeout: channel %0d ready stayed 0, required 1", which);
                return;
            end
        end
        @(posedge iCLK);
    endtask

    // wlast_beat < 0 means wlast on the final beat; abort_at >= 0 pulls reset during that beat.
    task automatic do_write(input logic [32:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [5:0] id, input int wlast_beat, input int abort_at);
        bit ok;
        int idx;
        logic [W-1:0] d;
        logic [SB-1:0] s;
        @(posedge iCLK);
        #1;
        i_awaddr = addr; i_awlen = len; i_awburst = burst; i_awid = id; i_awvalid = 1'b1;
        wait_ready(0, ok);
        #1 i_awvalid = 1'b0;
        if (!ok) return;
        idx = idx_of(addr);
        for (int k = 0; k <= int'(len); k++) begin
            d = wq_d.pop_front();
            s = wq_s.pop_front();
            i_wdata = d; i_wstrb = s; i_wvalid = 1'b1;
            i_wlast = (wlast_beat < 0) ? (k == int'(len)) : (k == wlast_beat);
            if (k == abort_at) begin
                #2 iRST = 1'b0;
                i_wvalid = 1'b0;
                return;
            end
            wait_ready(1, ok);
            #1 i_wvalid = 1'b0;
            if (!ok) return;
            for (int b = 0; b < SB; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            if (burst != 2'b00) idx = (idx + 1) % DEP;
        end
        exp_b.push_back({id, (wlast_beat >= 0 && wlast_beat != int'(len)) ? 2'b10 : 2'b00});
    endtask

    task automatic do_read(input logic [32:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [5:0] id);
        bit ok;
        int idx;
        @(posedge iCLK);
        #1;
        idx = idx_of(addr);
        for (int k = 0; k <= int'(len); k++) begin
            exp_rdata.push_back(model[idx]);
            exp_rlast.push_back(k == int'(len));
            exp_rid.push_back(id);
            if (burst != 2'b00) idx = (idx + 1) % DEP;
        end
        i_araddr = addr; i_arlen = len; i_arburst = burst; i_arid = id; i_arvalid = 1'b1;
        wait_ready(2, ok);
        #1 i_arvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((exp_rdata.size() != 0 || exp_b.size() != 0) && t < budget) begin
            @(negedge iCLK);
            t++;
        end
        if (t >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d read beats, %0d responses outstanding, required 0",
                     exp_rdata.size(), exp_b.size());
            exp_rdata.delete(); exp_rlast.delete(); exp_rid.delete(); exp_b.delete();
        end
    endtask

    task automatic push_beats(input int n, input bit full);
        for (int k = 0; k < n; k++) begin
            wq_d.push_back(rnd_word());
            wq_s.push_back(full ? {SB{1'b1}} : rnd_strb());
        end
    endtask

    // Release reset and check cfg_done timing; both address channels are held requesting.
    task automatic release_and_time_cfg();
        @(negedge iCLK);
        iRST = 1'b1;
        i_awvalid = 1'b1;
        i_arvalid = 1'b1;
        for (int i = 1; i <= CFG; i++) begin
            @(posedge iCLK);
            #1;
            check("cfg_done", W'(o_cfg_done), W'(i == CFG));
            check("ready_gate", W'({o_awready, o_arready}), W'((i == CFG) ? 2'b11 : 2'b00));
            check("no_bvalid", W'(o_bvalid), W'(0));
        end
        i_awvalid = 1'b0;
        i_arvalid = 1'b0;
    endtask

    logic [32:0] a;
    logic [7:0]  l;
    logic [1:0]  bt;
    logic [5:0]  id;

    initial begin
        iRST = 1'b1;
        {i_araddr, i_arlen, i_arburst, i_arid, i_arvalid} = '0;
        {i_awaddr, i_awlen, i_awburst, i_awid, i_awvalid} = '0;
        {i_wdata, i_wstrb, i_wlast, i_wvalid} = '0;
        i_rready = 1'b0;
        i_bready = 1'b0;
        #3 iRST = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        check("reset_outputs", W'({o_arready, o_rvalid, o_rlast, o_rid, o_awready, o_wready,
                                   o_bvalid, o_bid, o_bresp, o_cfg_done, o_wlast_err}), W'(0));
        check("reset_rdata", o_rdata, W'(0));
        release_and_time_cfg();

        // Fill the whole RAM with full-width 256-beat bursts.
        for (int blk = 0; blk < DEP / 256; blk++) begin
            push_beats(256, 1);
            do_write(33'(blk * 256 * SB), 8'd255, 2'b01, 6'(blk), -1, -1);
            drain(2000);
        end
        do_read(33'h0_0000_4000, 8'd255, 2'b01, 6'h2a);
        drain(3000);

        for (int k = 0; k < 4; k++) begin
            wq_d.push_back({16{32'hA5A50000 + k}});
            wq_s.push_back({SB{1'b1}});
        end
        do_write(33'h40, 8'd3, 2'b01, 6'h15, -1, -1);
        drain(200);
        do_read(33'h40, 8'd3, 2'b01, 6'h33);
        drain(200);

        wq_d.push_back({W{1'b1}}); wq_s.push_back({SB{1'b1}});
        do_write(33'h1000, 8'd0, 2'b01, 6'h01, -1, -1);
        wq_d.push_back(rnd_word()); wq_s.push_back(64'h00000000_0000000F);
        do_write(33'h1000, 8'd0, 2'b01, 6'h02, -1, -1);
        drain(200);
        do_read(33'h1000, 8'd0, 2'b01, 6'h03);
        drain(200);

        rr_mode = 1;
        pat_k = 0;
        do_read(33'h2000, 8'd7, 2'b01, 6'h07);
        drain(400);
        rr_mode = 0;

        push_beats(2, 1);
        do_write(33'h3000, 8'd1, 2'b01, 6'h0e, 0, -1);
        drain(200);
        check("wlast_err_set", W'(o_wlast_err), W'(1));
        push_beats(1, 1);
        do_write(33'h3040, 8'd0, 2'b01, 6'h0f, -1, -1);
        drain(200);
        check("wlast_err_sticky", W'(o_wlast_err), W'(1));

        push_beats(3, 1);
        do_write(33'h4000, 8'd2, 2'b00, 6'h11, -1, -1);
        drain(200);
        do_read(33'h4000, 8'd0, 2'b01, 6'h12);
        do_read(33'h4040, 8'd1, 2'b01, 6'h13);
        drain(200);

        for (int it = 0; it < 40; it++) begin
            a = {$urandom, $urandom};
            l = 8'($urandom_range(0, 15));
            bt = 2'($urandom_range(0, 3));
            id = 6'($urandom);
            push_beats(int'(l) + 1, 0);
            do_write(a, l, bt, id, -1, -1);
            drain(400);
            do_read(a, l, bt, id ^ 6'h3f);
            drain(400);
        end

        // Reset during beat 2 of an 8-beat write: beats 0 and 1 survive, no response.
        push_beats(8, 1);
        do_write(33'h5000, 8'd7, 2'b01, 6'h21, -1, 2);
        wq_d.delete();
        wq_s.delete();
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_mid_outputs", W'({o_bvalid, o_cfg_done, o_wready, o_wlast_err}), W'(0));
        release_and_time_cfg();
        do_read(33'h5000, 8'd7, 2'b01, 6'h22);
        drain(400);
        check("no_stray_bresp", W'(exp_b.size()), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
